mc_dac_buffered: RTL

Multi-channel, double-buffered, clocked R-string DAC model in SV-RNM. Each channel has an input register written through a valid/ready port and a DAC register transferred from all input registers together on a load-DAC strobe. Each channel drives a real-valued output equal to its DAC code times `vsup / 2**N`. It extends the single-channel combinational code-to-voltage DAC with multiple channels, synchronous update, clear, and an optional output slew limiter.

---
 rtl/mc_dac_pkg.sv | 31 +++
 rtl/dac_slew_ch.sv | 49 ++++
 rtl/mc_dac_buffered.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mc_dac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_dac_pkg : shared state type and arithmetic helpers for mc_dac  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package mc_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SLEW = 2'd2
    } state_t;

    function automatic real code_to_volt(input int unsigned code, input real vsup, input int n);
        return real'(code) * vsup / (2.0 ** n);
    endfunction

    // Move code toward target by at most step, landing exactly on target when close.
    function automatic int step_toward(input int code, input int target, input int step);
        int diff;
        diff = target - code;
        if (diff > step) begin
            return code + step;
        end else if (diff < -step) begin
            return code - step;
        end
        return target;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_slew_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_slew_ch : one channel's target/code registers and stepper     |
// | Built only when MC_DAC_SLEW_EN is defined.  Revision : 1.0        |
// +--------------------------------------------------------------------+
`ifdef MC_DAC_SLEW_EN
module dac_slew_ch
    import mc_dac_pkg::*;
#(
    parameter int N         = 3,
    parameter int SLEW_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         step_en,
    input  logic [N-1:0] target_in,
    output logic [N-1:0] code,
    output logic         done_next
);

    logic signed [N:0] diff;
    logic [N-1:0]      target_r;
    logic [N-1:0]      code_step;

    always_comb begin
        diff      = $signed({1'b0, target_r}) - $signed({1'b0, code});
        code_step = N'(step_toward(int'(code), int'(code) + int'(diff), SLEW_STEP));
        done_next = (code_step == target_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= '0;
            code     <= '0;
        end else if (clr) begin
            target_r <= '0;
            code     <= '0;
        end else if (load) begin
            target_r <= target_in;
        end else if (step_en) begin
            code     <= code_step;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/mc_dac_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_dac_buffered : multi-channel double-buffered R-string DAC model |
// | Optional output slew limiter: MC_DAC_SLEW_EN.  Revision : 1.0      |
// +--------------------------------------------------------------------+
module mc_dac_buffered
    import mc_dac_pkg::*;
#(
    parameter int N         = 3,
    parameter int CH        = 4,
    parameter int SLEW_STEP = 1,
    localparam int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  real               vsup,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [N-1:0]      wr_code,
    input  logic              ldac,
    input  logic              clr,
    output logic [CH*N-1:0]   dac_code,
    output real               vout [CH],
    output logic              settled
);

    generate
        if (CH < 1) begin : g_chk_ch
            $error("mc_dac_buffered: CH must be >= 1");
        end
        if (SLEW_STEP < 1) begin : g_chk_step
            $error("mc_dac_buffered: SLEW_STEP must be >= 1");
        end
    endgenerate

    state_t               state;
    state_t               state_nx;
    logic [CH-1:0][N-1:0] in_reg;
    logic [CH-1:0][N-1:0] code_q;
    logic                 accept;

    assign wr_ready = (state != ST_LOAD);
    assign accept   = wr_valid && wr_ready;
    assign settled  = (state == ST_IDLE);
    assign dac_code = code_q;

    // Out-of-range channel numbers match no slot, so the data falls away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            in_reg <= '0;
        end else if (clr) begin
            state  <= ST_IDLE;
            in_reg <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                for (int i = 0; i < CH; i++) begin
                    if (wr_ch == CHW'(i)) begin
                        in_reg[i] <= wr_code;
                    end
                end
            end
        end
    end

`ifdef MC_DAC_SLEW_EN
    logic [CH-1:0] ch_done;
    logic          all_done;
    logic          any_change;

    assign all_done   = &ch_done;
    assign any_change = (in_reg != code_q);

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            dac_slew_ch #(
                .N         (N),
                .SLEW_STEP (SLEW_STEP)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (clr),
                .load      (state == ST_LOAD),
                .step_en   (state == ST_SLEW),
                .target_in (in_reg[g]),
                .code      (code_q[g]),
                .done_next (ch_done[g])
            );
        end
    endgenerate
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
        end else if (clr) begin
            code_q <= '0;
        end else if (state == ST_LOAD) begin
            code_q <= in_reg;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (ldac) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef MC_DAC_SLEW_EN
                state_nx = any_change ? ST_SLEW : ST_IDLE;
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_SLEW: begin
`ifdef MC_DAC_SLEW_EN
                // All-done looks at post-step codes so IDLE follows the final step directly.
                if (ldac) begin
                    state_nx = ST_LOAD;
                end else if (all_done) begin
                    state_nx = ST_IDLE;
                end
`else
                state_nx = ST_IDLE;
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            vout[i] = code_to_volt(32'(code_q[i]), vsup, N);
        end
    end

endmodule
`default_nettype wire
